fc_seq: RTL and testbench



---
 rtl/fc_pkg.sv | 27 ++
 rtl/fc_sign_sum.sv | 24 ++
 rtl/fc_seq.sv | 170 +++++++++++++++++
 tb/tb_fc_seq.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared types and helpers for the time-multiplexed fully-connected classifier head.
package fc_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fc_state_t;

    // Number of weight words streamed per image.
    function automatic int fc_n(input int ic, input int oc, input int par);
        return oc * (ic / par);
    endfunction

    // Index width for a counter of n values, never narrower than one bit.
    function automatic int fc_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Clamp a wide signed accumulator into the signed w-bit range.
    function automatic logic signed [63:0] sat_w(input logic signed [63:0] acc, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (acc > hi) return hi;
        if (acc < lo) return lo;
        return acc;
    endfunction

endpackage

// File: rtl/fc_sign_sum.sv
// PAR-lane conditional-negate adder: bit 1 adds the weight, bit 0 subtracts it.
module fc_sign_sum #(
    parameter int PAR  = 8,
    parameter int W    = 16,
    parameter int ACCW = 26
) (
    input  logic [PAR-1:0]          bits,
    input  logic [PAR*W-1:0]        wts,
    output logic signed [ACCW-1:0]  psum
);

    always_comb begin
        logic signed [W-1:0]    wj;
        logic signed [ACCW-1:0] lane;
        psum = '0;
        for (int j = 0; j < PAR; j++) begin
            wj   = wts[j*W +: W];
            // Widen before negating so the most negative weight flips exactly.
            lane = ACCW'(wj);
            psum = bits[j] ? (psum + lane) : (psum - lane);
        end
    end

endmodule

// File: rtl/fc_seq.sv
// Sequential fully-connected classifier head: streams PAR weights per cycle,
// accumulates per class, saturates scores and tracks the argmax.
module fc_seq import fc_pkg::*; #(
    parameter int IC   = 288,
    parameter int OC   = 10,
    parameter int PAR  = 8,
    parameter int W    = 16,
    parameter int FRAC = 8,
    parameter int ACCW = W + $clog2(IC) + 1,
    localparam int AW  = fc_bits(fc_n(IC, OC, PAR)),
    localparam int CW  = fc_bits(OC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IC-1:0]     img_in,
    output logic              w_en,
    output logic [AW-1:0]     w_addr,
    input  logic [PAR*W-1:0]  w_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OC*W-1:0]   scores,
    output logic [CW-1:0]     class_idx
);

    localparam int CHUNKS = IC / PAR;
    localparam int N      = fc_n(IC, OC, PAR);
    localparam int CHW    = fc_bits(CHUNKS);

    if (IC % PAR != 0) begin : g_bad_par
        $error("fc_seq: IC must be divisible by PAR");
    end
    if (FRAC >= W) begin : g_bad_frac
        $error("fc_seq: FRAC must be smaller than W");
    end

    fc_state_t              state_q, state_d;
    logic [IC-1:0]          img_q, img_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [CHW-1:0]         chunk_q, chunk_d;
    logic [CW-1:0]          oc_q, oc_d;
    logic                   rd_vld_q, rd_vld_d;
    logic                   rd_last_q, rd_last_d;
    logic [CHW-1:0]         rd_chunk_q, rd_chunk_d;
    logic [CW-1:0]          rd_oc_q, rd_oc_d;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic [OC*W-1:0]        scores_q, scores_d;
    logic signed [W-1:0]    best_q, best_d;
    logic [CW-1:0]          cls_q, cls_d;

    logic [PAR-1:0]         slice;
    logic signed [ACCW-1:0] psum;
    logic                   accept;
    logic                   last_addr;

    assign accept    = (state_q == IDLE) && in_valid;
    assign last_addr = (addr_q == AW'(N - 1));
    assign slice     = img_q[int'(rd_chunk_q)*PAR +: PAR];

    fc_sign_sum #(.PAR(PAR), .W(W), .ACCW(ACCW)) u_sign_sum (
        .bits (slice),
        .wts  (w_rdata),
        .psum (psum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            img_q      <= '0;
            addr_q     <= '0;
            chunk_q    <= '0;
            oc_q       <= '0;
            rd_vld_q   <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_chunk_q <= '0;
            rd_oc_q    <= '0;
            acc_q      <= '0;
            scores_q   <= '0;
            best_q     <= '0;
            cls_q      <= '0;
        end else begin
            state_q    <= state_d;
            img_q      <= img_d;
            addr_q     <= addr_d;
            chunk_q    <= chunk_d;
            oc_q       <= oc_d;
            rd_vld_q   <= rd_vld_d;
            rd_last_q  <= rd_last_d;
            rd_chunk_q <= rd_chunk_d;
            rd_oc_q    <= rd_oc_d;
            acc_q      <= acc_d;
            scores_q   <= scores_d;
            best_q     <= best_d;
            cls_q      <= cls_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last_addr) state_d = DRAIN;
            DRAIN:                  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        w_en      = (state_q == RUN);
        out_valid = (state_q == DONE);
        w_addr    = addr_q;
        scores    = scores_q;
        class_idx = cls_q;
    end

    // Read tag travels one cycle behind the address, aligned with w_rdata.
    always_comb begin
        logic signed [ACCW-1:0] sum;
        logic signed [W-1:0]    cand;
        img_d      = img_q;
        addr_d     = addr_q;
        chunk_d    = chunk_q;
        oc_d       = oc_q;
        acc_d      = acc_q;
        scores_d   = scores_q;
        best_d     = best_q;
        cls_d      = cls_q;
        rd_vld_d   = (state_q == RUN);
        rd_last_d  = (chunk_q == CHW'(CHUNKS - 1));
        rd_chunk_d = chunk_q;
        rd_oc_d    = oc_q;
        sum        = acc_q + psum;
        cand       = W'(sat_w(longint'(sum), W));

        if (accept) begin
            img_d   = img_in;
            addr_d  = '0;
            chunk_d = '0;
            oc_d    = '0;
            acc_d   = '0;
        end

        if (state_q == RUN) begin
            if (!last_addr) addr_d = addr_q + AW'(1);
            if (chunk_q == CHW'(CHUNKS - 1)) begin
                chunk_d = '0;
                oc_d    = oc_q + CW'(1);
            end else begin
                chunk_d = chunk_q + CHW'(1);
            end
        end

        if (rd_vld_q) begin
            if (rd_last_q) begin
                scores_d[int'(rd_oc_q)*W +: W] = cand;
                acc_d = '0;
                if (rd_oc_q == '0 || cand > best_q) begin
                    best_d = cand;
                    cls_d  = rd_oc_q;
                end
            end else begin
                acc_d = sum;
            end
        end
    end

endmodule

// File: tb/tb_fc_seq.sv
// Bench for fc_seq: small-config vector table and corner sequences, plus
// randomized default-config runs against a behavioural model.
module tb_fc_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Small configuration: IC=8, OC=2, PAR=4, W=16
    logic         rst_s = 1'b1, in_valid_s = 1'b0, out_ready_s = 1'b0;
    logic         in_ready_s, w_en_s, out_valid_s;
    logic [7:0]   img_s = '0;
    logic [1:0]   w_addr_s;
    logic [63:0]  w_rdata_s = '0;
    logic [31:0]  scores_s;
    logic [0:0]   cls_s;
    logic [63:0]  mem_s [4];

    // Default configuration: IC=288, OC=10, PAR=8, W=16
    logic         rst_b = 1'b1, in_valid_b = 1'b0, out_ready_b = 1'b0;
    logic         in_ready_b, w_en_b, out_valid_b;
    logic [287:0] img_b = '0;
    logic [8:0]   w_addr_b;
    logic [127:0] w_rdata_b = '0;
    logic [159:0] scores_b;
    logic [3:0]   cls_b;
    logic [127:0] mem_b [360];

    fc_seq #(.IC(8), .OC(2), .PAR(4), .W(16), .FRAC(8)) u_small (
        .clk(clk), .rst(rst_s), .in_valid(in_valid_s), .in_ready(in_ready_s),
        .img_in(img_s), .w_en(w_en_s), .w_addr(w_addr_s), .w_rdata(w_rdata_s),
        .out_valid(out_valid_s), .out_ready(out_ready_s), .scores(scores_s),
        .class_idx(cls_s)
    );

    fc_seq u_big (
        .clk(clk), .rst(rst_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .img_in(img_b), .w_en(w_en_b), .w_addr(w_addr_b), .w_rdata(w_rdata_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .scores(scores_b),
        .class_idx(cls_b)
    );

    // Synchronous weight memories: data appears the cycle after w_en.
    always @(posedge clk) begin
        if (w_en_s) w_rdata_s <= mem_s[w_addr_s];
        if (w_en_b) w_rdata_b <= mem_b[w_addr_b];
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic start_s(input logic [7:0] img);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (in_ready_s) break;
        end
        in_valid_s = 1'b1;
        img_s      = img;
        @(posedge clk);
        #1 in_valid_s = 1'b0;
    endtask

    // Returns the cycle (accept cycle = 0) in which out_valid is first seen.
    task automatic run_s(input logic [7:0] img, input logic [15:0] w0, input logic [15:0] w1,
                         output int lat, output bit addr_ok);
        mem_s[0] = {4{w0}};
        mem_s[1] = {4{w0}};
        mem_s[2] = {4{w1}};
        mem_s[3] = {4{w1}};
        start_s(img);
        lat     = -1;
        addr_ok = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (out_valid_s) begin
                lat = c;
                break;
            end
            if (c <= 4) begin
                if (!w_en_s || w_addr_s != 2'(c - 1)) addr_ok = 1'b0;
            end else if (w_en_s) begin
                addr_ok = 1'b0;
            end
            @(posedge clk);
        end
    endtask

    task automatic release_s(input string nm);
        out_ready_s = 1'b1;
        @(posedge clk);
        #1 out_ready_s = 1'b0;
        @(negedge clk);
        chk({nm, "_in_ready"}, {in_ready_s, out_valid_s}, 2'b10);
    endtask

    // Reference: per-class signed sum over inputs, clamp, first strict maximum.
    function automatic void model_b(input logic [287:0] img, output logic [159:0] sc,
                                    output logic [3:0] cl);
        longint best;
        longint s;
        logic [127:0]       wd;
        logic signed [15:0] wv;
        best = 0;
        sc   = '0;
        cl   = '0;
        for (int oc = 0; oc < 10; oc++) begin
            s = 0;
            for (int i = 0; i < 288; i++) begin
                wd = mem_b[oc*36 + i/8];
                wv = wd[(i%8)*16 +: 16];
                s += img[i] ? longint'(wv) : -longint'(wv);
            end
            if (s > 32767)  s = 32767;
            if (s < -32768) s = -32768;
            sc[oc*16 +: 16] = 16'(s);
            if (oc == 0 || s > best) begin
                best = s;
                cl   = 4'(oc);
            end
        end
    endfunction

    task automatic run_b(input int mode, input int idx);
        logic [159:0] exp_sc;
        logic [3:0]   exp_cl;
        int           val;
        int           lat;
        for (int a = 0; a < 360; a++) begin
            for (int l = 0; l < 8; l++) begin
                case (mode)
                    0:       val = int'($urandom_range(0, 1023)) - 512;
                    1:       val = int'($urandom);
                    2:       val = ((a / 36) % 2 == 0) ? int'($urandom_range(0, 255)) - 128
                                                       : int'($urandom);
                    default: val = -32768;
                endcase
                mem_b[a][l*16 +: 16] = 16'(val);
            end
        end
        for (int k = 0; k < 9; k++) img_b[k*32 +: 32] = $urandom;
        model_b(img_b, exp_sc, exp_cl);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (in_ready_b) break;
        end
        in_valid_b = 1'b1;
        @(posedge clk);
        #1 in_valid_b = 1'b0;
        lat = -1;
        for (int c = 1; c <= 1000; c++) begin
            @(negedge clk);
            if (out_valid_b) begin
                lat = c;
                break;
            end
            @(posedge clk);
        end
        chk($sformatf("big%0d_latency", idx), lat, 362);
        chk($sformatf("big%0d_scores", idx), scores_b, exp_sc);
        chk($sformatf("big%0d_class", idx), cls_b, exp_cl);
        out_ready_b = 1'b1;
        @(posedge clk);
        #1 out_ready_b = 1'b0;
        @(negedge clk);
        chk($sformatf("big%0d_in_ready", idx), {in_ready_b, out_valid_b}, 2'b10);
    endtask

    typedef struct {
        logic [7:0]  img;
        logic [15:0] w0, w1;
        logic [15:0] e0, e1;
        logic        ec;
    } vec_t;

    initial begin
        vec_t         vt [8];
        int           lat;
        bit           aok;
        logic [31:0]  sc_hold;
        logic [0:0]   cl_hold;
        bit           spurious;

        vt[0] = '{8'hFF, 16'h0100, 16'h0100, 16'h0800, 16'h0800, 1'b0};
        vt[1] = '{8'h00, 16'h0100, 16'h0100, 16'hF800, 16'hF800, 1'b0};
        vt[2] = '{8'h0F, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 1'b0};
        vt[3] = '{8'hFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0};
        vt[4] = '{8'h00, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 1'b0};
        vt[5] = '{8'h00, 16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 1'b0};
        vt[6] = '{8'hFF, 16'h0010, 16'h0020, 16'h0080, 16'h0100, 1'b1};
        vt[7] = '{8'h00, 16'h0010, 16'h0020, 16'hFF80, 16'hFF00, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        rst_s = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        chk("reset_small", {in_ready_s, out_valid_s, w_en_s, w_addr_s, scores_s, cls_s},
            {1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0});
        chk("reset_big", {in_ready_b, out_valid_b, w_en_b, w_addr_b, scores_b, cls_b},
            {1'b1, 1'b0, 1'b0, 9'h0, 160'h0, 4'h0});

        for (int k = 0; k < 8; k++) begin
            run_s(vt[k].img, vt[k].w0, vt[k].w1, lat, aok);
            chk($sformatf("v%0d_latency", k), lat, 6);
            chk($sformatf("v%0d_addr_seq", k), aok, 1'b1);
            chk($sformatf("v%0d_scores", k), scores_s, {vt[k].e1, vt[k].e0});
            chk($sformatf("v%0d_class", k), cls_s, vt[k].ec);
            release_s($sformatf("v%0d", k));
        end

        // Backpressure: results held and a new image refused while out_ready is low.
        run_s(8'hFF, 16'h0010, 16'h0020, lat, aok);
        chk("bp_latency", lat, 6);
        sc_hold    = scores_s;
        cl_hold    = cls_s;
        in_valid_s = 1'b1;
        img_s      = 8'h00;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("bp%0d_hold", k), {scores_s, cls_s, in_ready_s, out_valid_s},
                {sc_hold, cl_hold, 1'b0, 1'b1});
        end
        in_valid_s = 1'b0;
        release_s("bp_release");
        chk("bp_kept_scores", scores_s, {16'h0100, 16'h0080});

        // Reset in the middle of a run discards the image.
        mem_s[0] = {4{16'h0100}};
        mem_s[1] = {4{16'h0100}};
        mem_s[2] = {4{16'h0100}};
        mem_s[3] = {4{16'h0100}};
        start_s(8'hFF);
        aok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (w_en_s && w_addr_s == 2'd2) begin
                aok = 1'b1;
                break;
            end
        end
        chk("rst_reached_addr2", aok, 1'b1);
        rst_s = 1'b1;
        @(posedge clk);
        #1 rst_s = 1'b0;
        @(negedge clk);
        chk("rst_mid_run", {in_ready_s, out_valid_s, w_en_s, scores_s, cls_s},
            {1'b1, 1'b0, 1'b0, 32'h0, 1'b0});
        spurious = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid_s || w_en_s) spurious = 1'b1;
        end
        chk("rst_no_output", spurious, 1'b0);
        run_s(8'h00, 16'h0100, 16'h0020, lat, aok);
        chk("post_rst_latency", lat, 6);
        chk("post_rst_scores", scores_s, {16'hFF00, 16'hF800});
        chk("post_rst_class", cls_s, 1'b1);
        release_s("post_rst");

        // Default configuration, randomized weights and images.
        run_b(0, 0);
        run_b(0, 1);
        run_b(1, 2);
        run_b(2, 3);
        run_b(3, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
